// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multdiv controller: FSM encoding, decode constants, exception codes.
package multdiv_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StBusy  = 2'd2,
        StWb    = 2'd3
    } state_e;

    localparam logic [4:0]  OpcodeRtype = 5'b00000;
    localparam logic [4:0]  AluopMul    = 5'b00110;
    localparam logic [4:0]  AluopDiv    = 5'b00111;
    localparam logic [4:0]  RstatusReg  = 5'd30;
    localparam logic [31:0] ExcCodeMul  = 32'd4;
    localparam logic [31:0] ExcCodeDiv  = 32'd5;

    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? ExcCodeDiv : ExcCodeMul;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Execute-stage, multdiv-unit and writeback signals of the multdiv controller.
interface multdiv_ctrl_if;
    logic        in_valid;
    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        md_result_rdy;
    logic        md_exception;
    logic [31:0] md_result;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_ack;

    modport master (
        input  in_valid, opcode, aluop, rd, operand_a, operand_b, flush,
               md_result_rdy, md_exception, md_result, wb_ack,
        output md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
               stall, wb_valid, wb_reg, wb_data
    );

    modport slave (
        output in_valid, opcode, aluop, rd, operand_a, operand_b, flush,
               md_result_rdy, md_exception, md_result, wb_ack,
        input  md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
               stall, wb_valid, wb_reg, wb_data
    );
endinterface

// File: rtl/multdiv_decode.sv
// Combinational detection of R-type mul/div instructions.
module multdiv_decode
    import multdiv_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [4:0] aluop,
    output logic       is_mul,
    output logic       is_div
);
    always_comb begin
        is_mul = (opcode == OpcodeRtype) && (aluop == AluopMul);
        is_div = (opcode == OpcodeRtype) && (aluop == AluopDiv);
    end
endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage, the iterative multdiv unit and register writeback.
// Optional BUSY watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input logic           clock,
    input logic           reset,
    multdiv_ctrl_if.master bus
);
    state_e      state_q, state_d;
    logic        div_q, div_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        is_mul, is_div, accept, wb_skip;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    multdiv_decode u_decode (
        .opcode (bus.opcode),
        .aluop  (bus.aluop),
        .is_mul (is_mul),
        .is_div (is_div)
    );

    always_comb begin
        accept  = bus.in_valid && (is_mul || is_div) && (state_q == StIdle) && !bus.flush;
        // rd==0 results are architecturally discarded; only exceptions still write back.
        wb_skip = !exc_q && (rd_q == 5'd0);
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rd_d    = rd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        exc_d   = exc_q;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d   = (state_q == StBusy) ? cnt_q + 1'b1 : '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    div_d   = is_div;
                    rd_d    = bus.rd;
                    opa_d   = bus.operand_a;
                    opb_d   = bus.operand_b;
                    res_d   = '0;
                    exc_d   = 1'b0;
                end
            end
            StStart: state_d = bus.flush ? StIdle : StBusy;
            StBusy: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (bus.md_result_rdy) begin
                    state_d = StWb;
                    res_d   = bus.md_result;
                    exc_d   = bus.md_exception;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StWb;
                    res_d   = '0;
                    exc_d   = 1'b1;
                end
`endif
            end
            StWb: begin
                if (wb_skip || bus.wb_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= 1'b0;
            rd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rd_q    <= rd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        // A flush landing in START kills the pulse before the unit sees it.
        bus.md_ctrl_mult = (state_q == StStart) && !div_q && !bus.flush;
        bus.md_ctrl_div  = (state_q == StStart) && div_q && !bus.flush;
        bus.md_operand_a = opa_q;
        bus.md_operand_b = opb_q;
        bus.stall        = accept || (state_q != StIdle);
        bus.wb_valid     = (state_q == StWb) && !wb_skip;
        bus.wb_reg       = '0;
        bus.wb_data      = '0;
        if (state_q == StWb) begin
            bus.wb_reg  = exc_q ? RstatusReg : rd_q;
            bus.wb_data = exc_q ? exc_code(div_q) : res_q;
        end
    end
endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 40, BUSY-state cycle limit (used only under REQ-031).
REQ-002 clock  in  1  rising-edge clock, sole clock domain.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 in_valid  in  1  instruction present in the execute stage.
REQ-005 opcode  in  5  instruction opcode field.
REQ-006 aluop  in  5  R-type ALU op field.
REQ-007 rd  in  5  destination register.
REQ-008 operand_a, operand_b  in  32 each  source operands.
REQ-009 flush  in  1  pipeline kill from branch/jump resolution.
REQ-010 md_ctrl_mult, md_ctrl_div  out  1 each  one-cycle start pulses to the iterative multdiv unit.
REQ-011 md_operand_a, md_operand_b  out  32 each  latched operands to the multdiv unit.
REQ-012 md_result_rdy  in  1; md_exception  in  1; md_result  in  32  multdiv unit completion, overflow/div-by-zero flag, result.
REQ-013 stall  out  1  freeze fetch/decode/execute.
REQ-014 wb_valid  out  1; wb_reg  out  5; wb_data  out  32  register-file write request.
REQ-015 wb_ack  in  1  register file accepted the write this cycle.

Function
REQ-016 Mul decode SHALL be opcode==00000 & aluop==00110; div decode SHALL be opcode==00000 & aluop==00111.
REQ-017 accept = in_valid & (mul|div) & state==IDLE & !flush; on accept operands, rd and op kind SHALL be latched.
REQ-018 States: IDLE, START, BUSY, WB; encoding in package.
REQ-019 IDLE->START on accept; START->BUSY unconditionally; BUSY->WB on md_result_rdy; WB->IDLE on wb_ack.
REQ-020 In START exactly one of md_ctrl_mult/md_ctrl_div SHALL be 1 for exactly one cycle; both 0 in all other states.
REQ-021 md_operand_a/b SHALL hold latched values from START through BUSY, unchanged until next accept.
REQ-022 In BUSY with md_result_rdy, md_result and md_exception SHALL be captured that cycle.
REQ-023 WB, no exception: wb_reg=latched rd, wb_data=captured result.
REQ-024 WB, exception: wb_reg=30, wb_data=4 (mul) or 5 (div).
REQ-025 WB, no exception and rd==0: wb_valid SHALL stay 0 and state SHALL return to IDLE next cycle.
REQ-026 wb_valid SHALL be 1 throughout WB (except REQ-025) with wb_reg/wb_data stable until wb_ack.
REQ-027 stall = accept | (state!=IDLE); it SHALL deassert the cycle after WB exits.
REQ-028 flush in START or BUSY SHALL return to IDLE next cycle, suppress any pending start pulse and discard any later md_result_rdy; flush in WB SHALL be ignored.
REQ-029 md_result_rdy outside BUSY SHALL be ignored.

Reset
REQ-030 reset low at a clock edge SHALL force IDLE and zero every output and latch, including mid-operation; start pulses SHALL NOT be issued in the cycle after reset release.

Configuration
REQ-031 With MULTDIV_TIMEOUT_EN defined, a counter SHALL count BUSY cycles; reaching TIMEOUT_CYCLES without md_result_rdy SHALL go to WB as an exception (REQ-024). Without it, BUSY SHALL wait indefinitely and no counter SHALL exist.

Structure
REQ-032 Shared package SHALL hold state encoding, opcode 00000, aluop codes 00110/00111, rstatus register 30, exception codes 4/5.
REQ-033 One sub-module, multdiv_decode (combinational mul/div detect), is natural; the FSM and latches stay in multdiv_ctrl.

Verification
REQ-034 mul, rd=5, A=7, B=6; rdy after 32 cycles with result 42 -> single mult pulse in START, stall high throughout, wb_reg=5, wb_data=42, stall low one cycle after wb_ack.
REQ-035 div, rd=3, B=0; rdy with md_exception=1 -> wb_reg=30, wb_data=5.
REQ-036 mul, rd=0, result 99 -> wb_valid never asserts; IDLE two cycles after rdy.
REQ-037 div accepted, flush in BUSY cycle 3, then rdy -> no wb_valid, stall low next cycle, rdy ignored.
REQ-038 reset low in BUSY, then rdy after release -> all outputs 0, no writeback.
REQ-039 MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=40, mul with no rdy -> WB at BUSY cycle 40, wb_reg=30, wb_data=4.
